// File: rtl/borrow_select_subtractor_seq_pkg.sv
// Shared definitions for the borrow-select subtractor: widths, legal n range, FSM states
// and the active-width mask helper.
package borrow_select_subtractor_seq_pkg;

    localparam int unsigned DW   = 5;
    localparam int unsigned LO_W = 2;
    localparam int unsigned HI_W = DW - LO_W;

    localparam logic [2:0] N_MIN = 3'd2;
    localparam logic [2:0] N_MAX = 3'd5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLow  = 2'd1,
        StSel  = 2'd2,
        StDone = 2'd3
    } state_e;

    // (1 << n) - 1, evaluated one bit wider so that n == DW does not overflow.
    function automatic logic [DW-1:0] mask(input logic [2:0] n);
        logic [DW:0] one;
        logic [DW:0] m;
        one = {{DW{1'b0}}, 1'b1};
        m   = (one << n) - one;
        return m[DW-1:0];
    endfunction

endpackage

// File: rtl/borrow_select_subtractor_seq_sub_slice.sv
// Combinational W-bit slice subtractor: {bout, diff} = a - b - bin.
module borrow_select_subtractor_seq_sub_slice #(
    parameter int unsigned W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] diff,
    output logic         bout
);

    logic [W:0] full;

    // The extra top bit goes to 1 exactly when the slice underflows.
    assign full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    assign diff = full[W-1:0];
    assign bout = full[W];

endmodule

// File: rtl/borrow_select_subtractor_seq.sv
// Sequential borrow-select subtractor: the low slice resolves the borrow while both
// speculative high-slice results are registered, then the borrow picks one of them.
module borrow_select_subtractor_seq
    import borrow_select_subtractor_seq_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [2:0]    n,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          bi,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] diff,
    output logic          bo,
    output logic          err
);

    state_e            state_q, state_d;
    logic [DW-1:0]     a_q, a_d, b_q, b_d;
    logic              bi_q, bi_d;
    logic [2:0]        n_q, n_d;
    logic [LO_W-1:0]   lo_diff_q, lo_diff_d;
    logic              lo_b_q, lo_b_d;
    logic [HI_W-1:0]   hi0_q, hi0_d, hi1_q, hi1_d;
    logic              hi0_b_q, hi0_b_d, hi1_b_q, hi1_b_d;
    logic [DW-1:0]     diff_q, diff_d;
    logic              bo_q, bo_d, err_q, err_d;

    logic [LO_W-1:0]   lo_diff_c;
    logic              lo_b_c;
    logic [HI_W-1:0]   hi0_c, hi1_c;
    logic              hi0_b_c, hi1_b_c;

    logic [HI_W-1:0]   hi_sel;
    logic              hi_sel_b;
    logic [DW:0]       full;
    logic              bo_sel;
    logic              legal;
    logic [DW-1:0]     m_in;

    borrow_select_subtractor_seq_sub_slice #(.W(LO_W)) u_lo (
        .a    (a_q[LO_W-1:0]),
        .b    (b_q[LO_W-1:0]),
        .bin  (bi_q),
        .diff (lo_diff_c),
        .bout (lo_b_c)
    );

    borrow_select_subtractor_seq_sub_slice #(.W(HI_W)) u_hi0 (
        .a    (a_q[DW-1:LO_W]),
        .b    (b_q[DW-1:LO_W]),
        .bin  (1'b0),
        .diff (hi0_c),
        .bout (hi0_b_c)
    );

    borrow_select_subtractor_seq_sub_slice #(.W(HI_W)) u_hi1 (
        .a    (a_q[DW-1:LO_W]),
        .b    (b_q[DW-1:LO_W]),
        .bin  (1'b1),
        .diff (hi1_c),
        .bout (hi1_b_c)
    );

    assign legal    = (n >= N_MIN) && (n <= N_MAX);
    assign m_in     = mask(n);
    assign hi_sel   = lo_b_q ? hi1_q : hi0_q;
    assign hi_sel_b = lo_b_q ? hi1_b_b_sel() : hi0_b_q;

    function automatic logic hi1_b_b_sel();
        return hi1_b_q;
    endfunction

    assign full = {hi_sel_b, hi_sel, lo_diff_q};

    // Operands are masked to n bits, so bit n of the wide result is the bit n-1 borrow.
    always_comb begin
        bo_sel = full[DW];
        case (n_q)
            3'd2:    bo_sel = full[2];
            3'd3:    bo_sel = full[3];
            3'd4:    bo_sel = full[4];
            default: bo_sel = full[DW];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        bi_d      = bi_q;
        n_d       = n_q;
        lo_diff_d = lo_diff_q;
        lo_b_d    = lo_b_q;
        hi0_d     = hi0_q;
        hi0_b_d   = hi0_b_q;
        hi1_d     = hi1_q;
        hi1_b_d   = hi1_b_q;
        diff_d    = diff_q;
        bo_d      = bo_q;
        err_d     = err_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (!start) begin
                    state_d = StIdle;
                end else if (legal) begin
                    a_d     = a & m_in;
                    b_d     = b & m_in;
                    bi_d    = bi;
                    n_d     = n;
                    state_d = StLow;
                end else begin
                    diff_d  = '0;
                    bo_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StLow: begin
                lo_diff_d = lo_diff_c;
                lo_b_d    = lo_b_c;
                hi0_d     = hi0_c;
                hi0_b_d   = hi0_b_c;
                hi1_d     = hi1_c;
                hi1_b_d   = hi1_b_c;
                state_d   = StSel;
            end
            StSel: begin
                diff_d  = full[DW-1:0] & mask(n_q);
                bo_d    = bo_sel;
                err_d   = 1'b0;
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            bi_q      <= 1'b0;
            n_q       <= '0;
            lo_diff_q <= '0;
            lo_b_q    <= 1'b0;
            hi0_q     <= '0;
            hi0_b_q   <= 1'b0;
            hi1_q     <= '0;
            hi1_b_q   <= 1'b0;
            diff_q    <= '0;
            bo_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            bi_q      <= bi_d;
            n_q       <= n_d;
            lo_diff_q <= lo_diff_d;
            lo_b_q    <= lo_b_d;
            hi0_q     <= hi0_d;
            hi0_b_q   <= hi0_b_d;
            hi1_q     <= hi1_d;
            hi1_b_q   <= hi1_b_d;
            diff_q    <= diff_d;
            bo_q      <= bo_d;
            err_q     <= err_d;
        end
    end

    assign busy = (state_q == StLow) || (state_q == StSel);
    assign done = (state_q == StDone);
    assign diff = diff_q;
    assign bo   = bo_q;
    assign err  = err_q;

endmodule

// File: tb/tb_borrow_select_subtractor_seq.sv
// Directed-vector bench for borrow_select_subtractor_seq: table of hand-computed results
// plus sequences for ignored start, back-to-back issue and reset mid-operation.
module tb_borrow_select_subtractor_seq;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [2:0] n;
    logic [4:0] a;
    logic [4:0] b;
    logic       bi;
    logic       busy;
    logic       done;
    logic [4:0] diff;
    logic       bo;
    logic       err;

    int n_vec;
    int n_checks;
    int miscompares;

    typedef struct packed {
        logic [2:0] n;
        logic [4:0] a;
        logic [4:0] b;
        logic       bi;
        logic [4:0] exp_diff;
        logic       exp_bo;
        logic       exp_err;
    } vec_t;

    vec_t vecs [14];

    borrow_select_subtractor_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .n       (n),
        .a       (a),
        .b       (b),
        .bi      (bi),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .bo      (bo),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Issues one operation and checks latency, busy duration and the result.
    // b2b: issue right after the previous done edge instead of waiting a cycle.
    // glitch: hold start with other operands during the LOW cycle.
    task automatic run_op(input vec_t v, input bit glitch, input bit b2b, input string tag);
        int lat;
        int busy_cnt;
        lat      = 0;
        busy_cnt = 0;
        if (!b2b) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        n     = v.n;
        a     = v.a;
        b     = v.b;
        bi    = v.bi;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                if (glitch) begin
                    start = 1'b1;
                    n     = 3'd5;
                    a     = 5'd1;
                    b     = 5'd2;
                    bi    = 1'b1;
                end else begin
                    start = 1'b0;
                    n     = 3'($urandom_range(0, 7));
                    a     = 5'($urandom);
                    b     = 5'($urandom);
                    bi    = 1'($urandom);
                end
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cnt++;
        end
        n_vec++;
        check({tag, " latency"}, 32'(lat), v.exp_err ? 32'd1 : 32'd3);
        check({tag, " busy cycles"}, 32'(busy_cnt), v.exp_err ? 32'd0 : 32'd2);
        check({tag, " diff"}, 32'(diff), 32'(v.exp_diff));
        check({tag, " bo"}, 32'(bo), 32'(v.exp_bo));
        check({tag, " err"}, 32'(err), 32'(v.exp_err));
    endtask

    initial begin
        int seen_done;
        n_vec       = 0;
        n_checks    = 0;
        miscompares = 0;
        start       = 1'b0;
        n           = 3'd0;
        a           = 5'd0;
        b           = 5'd0;
        bi          = 1'b0;
        reset_n     = 1'b0;

        //               n     a         b         bi    diff   bo    err
        vecs[0]  = '{3'd5, 5'd20,    5'd7,     1'b0, 5'd13, 1'b0, 1'b0};
        vecs[1]  = '{3'd5, 5'd3,     5'd4,     1'b1, 5'd30, 1'b1, 1'b0};
        vecs[2]  = '{3'd2, 5'b11101, 5'b00010, 1'b0, 5'd3,  1'b1, 1'b0};
        vecs[3]  = '{3'd4, 5'd4,     5'd1,     1'b0, 5'd3,  1'b0, 1'b0};
        vecs[4]  = '{3'd6, 5'd9,     5'd3,     1'b0, 5'd0,  1'b0, 1'b1};
        vecs[5]  = '{3'd1, 5'd1,     5'd0,     1'b0, 5'd0,  1'b0, 1'b1};
        vecs[6]  = '{3'd3, 5'b11010, 5'd3,     1'b1, 5'd6,  1'b1, 1'b0};
        vecs[7]  = '{3'd5, 5'd31,    5'd31,    1'b1, 5'd31, 1'b1, 1'b0};
        vecs[8]  = '{3'd5, 5'd31,    5'd0,     1'b0, 5'd31, 1'b0, 1'b0};
        vecs[9]  = '{3'd4, 5'd0,     5'd0,     1'b1, 5'd15, 1'b1, 1'b0};
        vecs[10] = '{3'd0, 5'd5,     5'd1,     1'b0, 5'd0,  1'b0, 1'b1};
        vecs[11] = '{3'd7, 5'd5,     5'd1,     1'b0, 5'd0,  1'b0, 1'b1};
        vecs[12] = '{3'd3, 5'd7,     5'd3,     1'b0, 5'd4,  1'b0, 1'b0};
        vecs[13] = '{3'd4, 5'b10110, 5'b01001, 1'b0, 5'd13, 1'b1, 1'b0};

        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset diff", 32'(diff), 32'd0);
        check("reset bo", 32'(bo), 32'd0);
        check("reset err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i], 1'b0, 1'b0, $sformatf("vec%0d", i));

        // start during LOW must be ignored
        run_op(vecs[0], 1'b1, 1'b0, "start-in-LOW");

        // start in the DONE cycle is accepted; each result three cycles after the last
        run_op(vecs[1], 1'b0, 1'b0, "b2b first");
        run_op(vecs[3], 1'b0, 1'b1, "b2b second");
        run_op(vecs[13], 1'b0, 1'b1, "b2b third");
        run_op(vecs[4], 1'b0, 1'b1, "b2b illegal");
        run_op(vecs[0], 1'b0, 1'b0, "pre-reset");

        // reset asserted in SEL clears everything at once and kills the operation
        @(posedge clk);
        #1;
        start = 1'b1;
        n     = 3'd5;
        a     = 5'd7;
        b     = 5'd1;
        bi    = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("in SEL busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid-reset busy", 32'(busy), 32'd0);
        check("mid-reset done", 32'(done), 32'd0);
        check("mid-reset diff", 32'(diff), 32'd0);
        check("mid-reset bo", 32'(bo), 32'd0);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        seen_done = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        check("no done after reset", 32'(seen_done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end

endmodule
